// File: rtl/uart_reg_pkg.sv
// Shared constants and state encoding for the uart register-access responder.
package uart_reg_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_WRITE,
        ST_READ_REQ,
        ST_READ_WAIT,
        ST_RESP
    } state_t;

    // States in which a command byte may be taken from the receive stream.
    function automatic logic rx_state(input state_t s);
        return s inside {ST_IDLE, ST_ADDR, ST_WDATA};
    endfunction

    // States guarded by the inactivity timeout.
    function automatic logic tmo_state(input state_t s);
        return s inside {ST_ADDR, ST_WDATA, ST_READ_WAIT};
    endfunction

endpackage

// File: rtl/uart_reg_timeout.sv
// Inactivity counter: counts while enabled, clears on demand, and flags the
// cycle in which the count reaches TIMEOUT.
module uart_reg_timeout #(
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire_c
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != CNT_W'(TIMEOUT))) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Fires on the edge that would take the count to TIMEOUT.
    assign o_expire_c = i_en && !i_clr && (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/uart_reg_responder.sv
// Responder for the host register-access protocol over uart byte streams:
// decodes write/read commands, drives the register bus, returns ACK/NAK/data.
module uart_reg_responder
    import uart_reg_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned REG_BYTES  = 4,
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [7:0]              m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [ADDR_WIDTH-1:0]   reg_addr,
    output logic [8*REG_BYTES-1:0]  reg_wdata,
    output logic                    reg_we,
    output logic                    reg_re,
    input  logic [8*REG_BYTES-1:0]  reg_rdata,
    input  logic                    reg_rvalid,
    output logic                    timeout_error
);
    localparam int unsigned DATA_W = 8 * REG_BYTES;
    localparam int unsigned BCNT_W = $clog2(REG_BYTES + 1);

    state_t              r_state, w_state_nxt;
    logic                r_op_write, w_op_write_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
    logic [DATA_W-1:0]   r_shift, w_shift_nxt;
    logic [BCNT_W-1:0]   r_count, w_count_nxt;
    logic                r_s_tready, r_m_tvalid, r_we, r_re, r_timeout_error;
    logic                w_timeout_nxt;
    logic                w_s_acc, w_m_acc, w_tmo_en, w_tmo_clr, w_tmo_expire;

    assign w_s_acc   = s_axis_tvalid && r_s_tready;
    assign w_m_acc   = r_m_tvalid && m_axis_tready;
    assign w_tmo_en  = tmo_state(r_state);
    assign w_tmo_clr = w_s_acc || !w_tmo_en;

    uart_reg_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clr      (w_tmo_clr),
        .i_en       (w_tmo_en),
        .o_expire_c (w_tmo_expire)
    );

    // Next-state and datapath decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_op_write_nxt = r_op_write;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_shift_nxt    = r_shift;
        w_count_nxt    = r_count;
        w_timeout_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_s_acc) begin
                    if (s_axis_tdata == OP_WRITE) begin
                        w_op_write_nxt = 1'b1;
                        w_state_nxt    = ST_ADDR;
                    end else if (s_axis_tdata == OP_READ) begin
                        w_op_write_nxt = 1'b0;
                        w_state_nxt    = ST_ADDR;
                    end else begin
                        w_shift_nxt                 = '0;
                        w_shift_nxt[DATA_W-1 -: 8]  = RSP_NAK;
                        w_count_nxt                 = BCNT_W'(1);
                        w_state_nxt                 = ST_RESP;
                    end
                end
            end
            ST_ADDR: begin
                if (w_s_acc) begin
                    w_addr_nxt  = s_axis_tdata[ADDR_WIDTH-1:0];
                    w_count_nxt = '0;
                    w_state_nxt = r_op_write ? ST_WDATA : ST_READ_REQ;
                end else if (w_tmo_expire) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_WDATA: begin
                if (w_s_acc) begin
                    w_wdata_nxt = DATA_W'({r_wdata, s_axis_tdata});
                    if (r_count == BCNT_W'(REG_BYTES - 1)) begin
                        w_state_nxt = ST_WRITE;
                    end else begin
                        w_count_nxt = r_count + BCNT_W'(1);
                    end
                end else if (w_tmo_expire) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_WRITE: begin
                w_shift_nxt                = '0;
                w_shift_nxt[DATA_W-1 -: 8] = RSP_ACK;
                w_count_nxt                = BCNT_W'(1);
                w_state_nxt                = ST_RESP;
            end
            ST_READ_REQ: begin
                w_state_nxt = ST_READ_WAIT;
            end
            ST_READ_WAIT: begin
                // Data arriving on the expiry edge still wins over the NAK.
                if (reg_rvalid) begin
                    w_shift_nxt = reg_rdata;
                    w_count_nxt = BCNT_W'(REG_BYTES);
                    w_state_nxt = ST_RESP;
                end else if (w_tmo_expire) begin
                    w_shift_nxt                = '0;
                    w_shift_nxt[DATA_W-1 -: 8] = RSP_NAK;
                    w_count_nxt                = BCNT_W'(1);
                    w_timeout_nxt              = 1'b1;
                    w_state_nxt                = ST_RESP;
                end
            end
            ST_RESP: begin
                if (w_m_acc) begin
                    w_shift_nxt = r_shift << 8;
                    w_count_nxt = r_count - BCNT_W'(1);
                    if (r_count == BCNT_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Strobes and handshakes are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_op_write      <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_shift         <= '0;
            r_count         <= '0;
            r_s_tready      <= 1'b0;
            r_m_tvalid      <= 1'b0;
            r_we            <= 1'b0;
            r_re            <= 1'b0;
            r_timeout_error <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_op_write      <= w_op_write_nxt;
            r_addr          <= w_addr_nxt;
            r_wdata         <= w_wdata_nxt;
            r_shift         <= w_shift_nxt;
            r_count         <= w_count_nxt;
            r_s_tready      <= rx_state(w_state_nxt);
            r_m_tvalid      <= (w_state_nxt == ST_RESP);
            r_we            <= (w_state_nxt == ST_WRITE);
            r_re            <= (w_state_nxt == ST_READ_REQ);
            r_timeout_error <= w_timeout_nxt;
        end
    end

    assign s_axis_tready = r_s_tready;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_shift[DATA_W-1 -: 8];
    assign reg_addr      = r_addr;
    assign reg_wdata     = r_wdata;
    assign reg_we        = r_we;
    assign reg_re        = r_re;
    assign timeout_error = r_timeout_error;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Self-checking bench for uart_reg_responder: command vector table plus
// hand-built timeout, latency and reset sequences, with byte/bus scoreboards.
module tb_uart_reg_responder;

    localparam int unsigned TMO = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [31:0] reg_rdata;
    logic        reg_rvalid;
    logic        timeout_error;

    always #5 clk = ~clk;

    uart_reg_responder #(
        .ADDR_WIDTH (8),
        .REG_BYTES  (4),
        .TIMEOUT    (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_we        (reg_we),
        .reg_re        (reg_re),
        .reg_rdata     (reg_rdata),
        .reg_rvalid    (reg_rvalid),
        .timeout_error (timeout_error)
    );

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rlat;
        int          trmode;   // 0: tready high, 1: toggling
        int          nrsp;
        logic [31:0] rsp;      // expected bytes, left-aligned
        int          n_we;
        int          n_re;
        logic [7:0]  exp_addr;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int rsp_cnt  = 0;
    int we_cnt   = 0;
    int re_cnt   = 0;
    int te_cnt   = 0;
    int tr_mode  = 0;          // 0: high, 1: toggle, 2: driven by sequence

    logic [7:0]  exp_q[$];
    logic [39:0] we_q[$];
    logic [7:0]  re_q[$];
    vec_t        vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic       prev_hold = 1'b0;
        logic       prev_rst  = 1'b0;
        logic [7:0] prev_data = 8'h00;
        forever begin
            @(negedge clk);
            if (prev_hold && !rst && !prev_rst)
                chk("rsp_hold", 64'({m_axis_tvalid, m_axis_tdata}), 64'({1'b1, prev_data}));
            prev_hold = m_axis_tvalid && !m_axis_tready && !rst;
            prev_data = m_axis_tdata;
            prev_rst  = rst;
            if (m_axis_tvalid)
                chk("s_ready_in_resp", 64'(s_axis_tready), 64'(0));
            if (m_axis_tvalid && m_axis_tready && !rst) begin
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got %02h expected no byte", m_axis_tdata);
                end else begin
                    chk("rsp_byte", 64'(m_axis_tdata), 64'(exp_q.pop_front()));
                end
            end
            if (reg_we) begin
                we_cnt++;
                if (we_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL we_unexpected: got addr %02h data %08h expected no write", reg_addr, reg_wdata);
                end else begin
                    chk("we_addr_data", 64'({reg_addr, reg_wdata}), 64'(we_q.pop_front()));
                end
            end
            if (reg_re) begin
                re_cnt++;
                if (re_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL re_unexpected: got addr %02h expected no read", reg_addr);
                end else begin
                    chk("re_addr", 64'(reg_addr), 64'(re_q.pop_front()));
                end
            end
            if (timeout_error) te_cnt++;
        end
    endtask

    task automatic tready_drv();
        forever begin
            @(posedge clk);
            #1;
            case (tr_mode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = ~m_axis_tready;
                default: ;
            endcase
        end
    endtask

    task automatic watchdog();
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got still running expected finish within 60000 cycles");
        $fatal(1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bit done = 1'b0;
        @(posedge clk);
        #1;
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        while (!done && n < 200) begin
            @(negedge clk);
            if (s_axis_tready) done = 1'b1;
            else n++;
        end
        if (done) begin
            @(posedge clk);
            #1;
        end else begin
            checks++;
            failures++;
            $display("FAIL s_accept: got tready low 200 cycles expected byte %02h accepted", b);
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic rvalid_after_re(input logic [31:0] d, input int lat);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (reg_re) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL re_wait: got no reg_re expected reg_re within 50 cycles");
        end else begin
            repeat (lat) @(posedge clk);
            #1;
            reg_rvalid = 1'b1;
            reg_rdata  = d;
            @(posedge clk);
            #1;
            reg_rvalid = 1'b0;
            reg_rdata  = 32'hBAD0_BAD0;
        end
    endtask

    task automatic wait_drain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && s_axis_tready && !m_axis_tvalid) ok = 1'b1;
        end
        chk({name, "_drain"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        int we0 = we_cnt;
        int re0 = re_cnt;
        int te0 = te_cnt;
        int r0  = rsp_cnt;
        for (int k = 0; k < v.nrsp; k++) exp_q.push_back(v.rsp[31-8*k -: 8]);
        if (v.n_we != 0) we_q.push_back({v.exp_addr, v.wdata});
        if (v.n_re != 0) re_q.push_back(v.exp_addr);
        tr_mode = v.trmode;
        send_byte(v.op);
        if (v.op == 8'h57) begin
            send_byte(v.addr);
            for (int k = 0; k < 4; k++) send_byte(v.wdata[31-8*k -: 8]);
        end else if (v.op == 8'h52) begin
            send_byte(v.addr);
            rvalid_after_re(v.rdata, v.rlat);
        end
        wait_drain($sformatf("vec%0d", idx));
        chk($sformatf("vec%0d_we_count", idx), 64'(we_cnt - we0), 64'(v.n_we));
        chk($sformatf("vec%0d_re_count", idx), 64'(re_cnt - re0), 64'(v.n_re));
        chk($sformatf("vec%0d_rsp_count", idx), 64'(rsp_cnt - r0), 64'(v.nrsp));
        chk($sformatf("vec%0d_timeout", idx), 64'(te_cnt - te0), 64'(0));
        tr_mode = 0;
    endtask

    initial begin
        int   we0, re0, te0, r0, tpos;
        bit   seen;
        vec_t v;

        vecs[0] = '{8'h57, 8'h05, 32'hDEADBEEF, 32'h0,        0, 0, 1, 32'h0600_0000, 1, 0, 8'h05};
        vecs[1] = '{8'h52, 8'h0A, 32'h0,        32'h12345678, 3, 0, 4, 32'h1234_5678, 0, 1, 8'h0A};
        vecs[2] = '{8'h52, 8'h33, 32'h0,        32'hCAFEF00D, 1, 1, 4, 32'hCAFE_F00D, 0, 1, 8'h33};
        vecs[3] = '{8'h41, 8'h00, 32'h0,        32'h0,        0, 0, 1, 32'h1500_0000, 0, 0, 8'h00};
        vecs[4] = '{8'h57, 8'hFF, 32'h01020304, 32'h0,        0, 1, 1, 32'h0600_0000, 1, 0, 8'hFF};
        vecs[5] = '{8'h52, 8'hFF, 32'h0,        32'hA5C35A3C, 6, 1, 4, 32'hA5C3_5A3C, 0, 1, 8'hFF};
        vecs[6] = '{8'h00, 8'h00, 32'h0,        32'h0,        0, 0, 1, 32'h1500_0000, 0, 0, 8'h00};
        vecs[7] = '{8'h57, 8'h80, 32'h80000001, 32'h0,        0, 0, 1, 32'h0600_0000, 1, 0, 8'h80};

        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        reg_rdata     = 32'hBAD0_BAD0;
        reg_rvalid    = 1'b0;
        m_axis_tready = 1'b0;
        fork
            monitor();
            tready_drv();
            watchdog();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", 64'(s_axis_tready), 64'(0));
        chk("rst_m_tvalid_tdata", 64'({m_axis_tvalid, m_axis_tdata}), 64'(0));
        chk("rst_strobes", 64'({reg_we, reg_re, timeout_error}), 64'(0));
        chk("rst_addr_wdata", 64'({reg_addr, reg_wdata}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) apply_vec(vecs[i], i);

        // Write latency: reg_we one cycle after the last data byte, ACK one later.
        tr_mode       = 2;
        m_axis_tready = 1'b0;
        we_q.push_back({8'h11, 32'h0BADF00D});
        exp_q.push_back(8'h06);
        send_byte(8'h57);
        send_byte(8'h11);
        send_byte(8'h0B);
        send_byte(8'hAD);
        send_byte(8'hF0);
        send_byte(8'h0D);
        @(negedge clk);
        chk("lat_we_n1", 64'(reg_we), 64'(1));
        chk("lat_tvalid_n1", 64'(m_axis_tvalid), 64'(0));
        @(negedge clk);
        chk("lat_we_n2", 64'(reg_we), 64'(0));
        chk("lat_ack_n2", 64'({m_axis_tvalid, m_axis_tdata}), 64'(9'h106));
        tr_mode = 0;
        wait_drain("lat");

        // Stalled write frame: abort exactly TMO cycles after the last byte.
        we0 = we_cnt; te0 = te_cnt; r0 = rsp_cnt;
        send_byte(8'h57);
        send_byte(8'h05);
        send_byte(8'hAA);
        tpos = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (timeout_error && tpos == 0) tpos = n;
        end
        chk("tmo_wdata_pos", 64'(tpos), 64'(TMO));
        chk("tmo_wdata_pulses", 64'(te_cnt - te0), 64'(1));
        chk("tmo_wdata_no_we", 64'(we_cnt - we0), 64'(0));
        chk("tmo_wdata_no_rsp", 64'(rsp_cnt - r0), 64'(0));
        chk("tmo_wdata_idle", 64'(s_axis_tready), 64'(1));
        v = '{8'h52, 8'h00, 32'h0, 32'h00C0FFEE, 2, 0, 4, 32'h00C0_FFEE, 0, 1, 8'h00};
        apply_vec(v, 8);

        // Read with no reg_rvalid ends in NAK plus a timeout pulse.
        te0 = te_cnt; re0 = re_cnt; r0 = rsp_cnt;
        re_q.push_back(8'h07);
        exp_q.push_back(8'h15);
        send_byte(8'h52);
        send_byte(8'h07);
        wait_drain("tmo_read");
        chk("tmo_read_pulses", 64'(te_cnt - te0), 64'(1));
        chk("tmo_read_re", 64'(re_cnt - re0), 64'(1));
        chk("tmo_read_rsp", 64'(rsp_cnt - r0), 64'(1));

        // Stray reg_rvalid in IDLE must not produce a response.
        r0 = rsp_cnt;
        @(posedge clk);
        #1;
        reg_rvalid = 1'b1;
        reg_rdata  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        reg_rvalid = 1'b0;
        reg_rdata  = 32'hBAD0_BAD0;
        repeat (5) @(negedge clk);
        chk("stray_rvalid_rsp", 64'(rsp_cnt - r0), 64'(0));
        chk("stray_rvalid_idle", 64'(s_axis_tready), 64'(1));

        // Reset after two of four read bytes: remainder is discarded.
        tr_mode       = 2;
        m_axis_tready = 1'b0;
        r0            = rsp_cnt;
        re_q.push_back(8'h0B);
        exp_q.push_back(8'h89);
        exp_q.push_back(8'hAB);
        send_byte(8'h52);
        send_byte(8'h0B);
        rvalid_after_re(32'h89ABCDEF, 2);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (m_axis_tvalid) seen = 1'b1;
        end
        chk("rr_tvalid", 64'(m_axis_tvalid), 64'(1));
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        m_axis_tready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rr_tvalid_after_rst", 64'(m_axis_tvalid), 64'(0));
        chk("rr_rsp_count", 64'(rsp_cnt - r0), 64'(2));
        chk("rr_queue_empty", 64'(exp_q.size()), 64'(0));
        tr_mode = 0;
        repeat (10) @(negedge clk);
        chk("rr_no_more_bytes", 64'(rsp_cnt - r0), 64'(2));
        v = '{8'h57, 8'h22, 32'h13579BDF, 32'h0, 0, 0, 1, 32'h0600_0000, 1, 0, 8'h22};
        apply_vec(v, 9);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_reg_responder.md
Name: uart_reg_responder

Overview:
- Responder end of the host-to-FPGA register-access protocol carried over the uart byte streams.
- Consumes command bytes from the uart receive stream and executes register writes and reads on a simple register bus.
- Emits response bytes on the uart transmit stream.
- Sits between the uart block and the register file; the host is the initiator.

Parameters:
- ADDR_WIDTH, 8, register address width; must be <= 8 (one address byte).
- REG_BYTES, 4, register width in bytes; register data width is 8*REG_BYTES, sent MSB first.
- TIMEOUT, 100000, cycles allowed between command bytes, and for reg_rvalid after reg_re, before abort.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_tdata  in  8  command byte from uart rx
- s_axis_tvalid  in  1  command byte valid
- s_axis_tready  out  1  command byte accepted
- m_axis_tdata  out  8  response byte to uart tx
- m_axis_tvalid  out  1  response byte valid
- m_axis_tready  in  1  uart tx ready
- reg_addr  out  ADDR_WIDTH  register address
- reg_wdata  out  8*REG_BYTES  write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8*REG_BYTES  read data, sampled when reg_rvalid=1
- reg_rvalid  in  1  read data valid, arbitrary latency >= 1 cycle after reg_re
- timeout_error  out  1  one-cycle pulse on any timeout abort

Behaviour:
- Reset: synchronous active-high. State=IDLE. s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, reg_we=0, reg_re=0, reg_addr=0, reg_wdata=0, timeout_error=0. rst mid-frame or mid-response discards everything; no partial response is completed.
- Protocol:
  - Write: 0x57, addr, REG_BYTES data bytes MSB first -> response 0x06 (ACK).
  - Read: 0x52, addr -> response REG_BYTES data bytes MSB first.
  - Any other opcode in IDLE -> response 0x15 (NAK).
  - addr byte: low ADDR_WIDTH bits used, upper bits ignored.
- Byte transfer: a byte moves when tvalid && tready on the same rising edge.
- s_axis_tready: 1 only in IDLE, ADDR and WDATA; 0 otherwise, so the receiver backpressures during bus access and response.
- m_axis: tdata is stable while tvalid=1 && tready=0; tvalid does not drop until accepted.
- States:
  - IDLE: accept opcode. 0x57 -> ADDR (op=W). 0x52 -> ADDR (op=R). Else load NAK -> RESP with count=1.
  - ADDR: accept byte into reg_addr. op=W -> WDATA, byte count=0. op=R -> READ_REQ.
  - WDATA: shift each byte into reg_wdata from the LSB end. On the REG_BYTES-th byte -> WRITE.
  - WRITE: reg_we=1 for exactly one cycle; reg_addr/reg_wdata valid that cycle. Load ACK -> RESP, count=1.
  - READ_REQ: reg_re=1 for one cycle -> READ_WAIT.
  - READ_WAIT: on reg_rvalid latch reg_rdata into the response shift register -> RESP, count=REG_BYTES. reg_rvalid outside READ_WAIT is ignored.
  - RESP: m_axis_tvalid=1, tdata=shift register MSB byte. On accept, shift left by 8 and decrement count. Accepting the last byte -> IDLE, with tvalid=0 the next cycle.
- Latency: last write-data byte accepted at edge N -> reg_we high in cycle N+1 -> ACK tvalid in cycle N+2.
- Timeout: counter clears on every accepted s_axis byte and on entry to READ_WAIT; it counts in ADDR, WDATA and READ_WAIT.
  - Reaching TIMEOUT in ADDR/WDATA -> IDLE, no bus access, no response.
  - Reaching TIMEOUT in READ_WAIT -> NAK response.
  - Both cases pulse timeout_error for one cycle.
  - No timeout applies in IDLE or RESP; RESP waits on m_axis_tready indefinitely.
- Width: counter sized $clog2(TIMEOUT+1); byte count sized $clog2(REG_BYTES+1).

Decomposition:
- Shared package uart_reg_pkg: opcode constants OP_WRITE=8'h57, OP_READ=8'h52; response constants RSP_ACK=8'h06, RSP_NAK=8'h15; state enum typedef.
- One natural sub-module: uart_reg_timeout (loadable cycle counter with clear/enable and an expiry pulse).
- Everything else stays in one FSM.

Test Plan:
- Write: bytes 57 05 DE AD BE EF with tready=1 -> one reg_we pulse with reg_addr=05, reg_wdata=DEADBEEF; m_axis emits single 06.
- Read: bytes 52 0A, reg_rvalid 3 cycles after reg_re with rdata=12345678 -> m_axis emits 12 34 56 78 in order, one reg_re pulse.
- Backpressure: read with m_axis_tready toggling 1/0 each cycle -> every byte held stable until accepted; s_axis_tready=0 throughout RESP; exactly 4 bytes out.
- Unknown opcode 0x41 -> m_axis emits 15; no reg_we/reg_re; a following write command completes normally.
- Timeout: TIMEOUT=50, send 57 05 AA then idle 60 cycles -> timeout_error pulse at 50 cycles after AA, no reg_we, no response; next 52 00 is treated as a new command. Read with no reg_rvalid -> 15 plus a timeout_error pulse.
- Reset mid-RESP after 2 of 4 read bytes accepted -> m_axis_tvalid=0 the cycle after reset; resumes from IDLE.
